line_follow_sequencer: RTL and testbench

LINE_FOLLOW_SEQUENCER -- requirements
Module: line_follow_sequencer

---
 rtl/robot_pkg.sv | 27 ++
 rtl/sensor_debounce.sv | 41 ++++
 rtl/line_follow_sequencer.sv | 160 ++++++++++++++++
 tb/tb_line_follow_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared definitions for the line-follow robot sequencer.
//   - FSM state encoding, reported on state_o
//   - steering direction encoding, remembered as last_dir
//   - default debounce length and search timeout
//   - helper that turns a PWM counter and a duty value into a wheel level
package robot_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEB_CYCLES_DEFAULT     = 4;
  localparam int SEARCH_TIMEOUT_DEFAULT = 64;

  localparam int PWM_W = 4;

  // Duty 0 is always low; duty 15 is high for 15 of every 16 counts.
  function automatic logic pwm_on(input logic [PWM_W-1:0] cnt,
                                  input logic [PWM_W-1:0] duty);
    return (cnt < duty);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounce filter for one raw line sensor.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   raw        - raw sensor level (1 = line seen)
//   filtered   - filtered level; resets to 1
// The filtered value follows raw only after raw has disagreed with it for
// DEB_CYCLES consecutive cycles. A single agreeing cycle restarts the count.
module sensor_debounce
  import robot_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      filtered <= 1'b1;
      cnt      <= '0;
    end else if (raw != filtered) begin
      // The current cycle is the DEB_CYCLES-th disagreeing one.
      if (cnt == CNT_LAST) begin
        filtered <= raw;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/line_follow_sequencer.sv
// Line-follow robot sequencer: debounces two line sensors, steers two PWM
// wheels, spins to re-acquire a lost line, and halts after a search timeout.
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   start, stop              - level requests; stop wins over everything but reset
//   sensorLeft, sensorRight  - raw line sensors (1 = line seen)
//   duty_fast, duty_slow     - PWM duty (n/16) for the fast and slow wheel
//   motorLeft, motorRight    - registered PWM wheel drive
//   state_o                  - registered state (IDLE=0 RUN=1 SEARCH=2 HALT=3)
//   lost                     - registered flag, set when the search timed out
module line_follow_sequencer
  import robot_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEFAULT,
  parameter int SEARCH_TIMEOUT = SEARCH_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sensorLeft,
  input  logic             sensorRight,
  input  logic [PWM_W-1:0] duty_fast,
  input  logic [PWM_W-1:0] duty_slow,
  output logic             motorLeft,
  output logic             motorRight,
  output logic [1:0]       state_o,
  output logic             lost
);

  localparam int SC_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [SC_W-1:0] SEARCH_LAST = SC_W'(SEARCH_TIMEOUT - 1);

  logic             filt_left;
  logic             filt_right;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             lost_nxt;
  logic             last_dir;
  logic             dir_nxt;
  logic [SC_W-1:0]  search_cnt;
  logic [SC_W-1:0]  search_nxt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_left;
  logic [PWM_W-1:0] duty_right;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk      (clk),
    .reset    (reset),
    .raw      (sensorLeft),
    .filtered (filt_left)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk      (clk),
    .reset    (reset),
    .raw      (sensorRight),
    .filtered (filt_right)
  );

  // Per-wheel duty selected from the current state; duty 0 keeps a wheel off.
  // While RUN sees both sensors dark the wheels coast for the single cycle
  // before SEARCH takes over.
  always_comb begin
    duty_left  = '0;
    duty_right = '0;
    case (state)
      ST_RUN: begin
        case ({filt_left, filt_right})
          2'b11: begin duty_left = duty_fast; duty_right = duty_fast; end
          2'b01: begin duty_left = duty_slow; duty_right = duty_fast; end
          2'b10: begin duty_left = duty_fast; duty_right = duty_slow; end
          default: ;
        endcase
      end
      ST_SEARCH: begin
        if (last_dir == DIR_LEFT) duty_right = duty_fast;
        else                      duty_left  = duty_fast;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    lost_nxt   = lost;
    dir_nxt    = last_dir;
    search_nxt = search_cnt;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        case ({filt_left, filt_right})
          2'b01: dir_nxt = DIR_LEFT;
          2'b10: dir_nxt = DIR_RIGHT;
          2'b00: begin
            state_nxt  = ST_SEARCH;
            search_nxt = '0;
          end
          default: ;
        endcase
      end
      ST_SEARCH: begin
        // Recovery is checked first so it wins over a coincident timeout.
        if (filt_left || filt_right) begin
          state_nxt = ST_RUN;
        end else if (search_cnt == SEARCH_LAST) begin
          state_nxt = ST_HALT;
          lost_nxt  = 1'b1;
        end else begin
          search_nxt = search_cnt + 1'b1;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_nxt = ST_RUN;
          lost_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (stop) begin
      state_nxt  = ST_IDLE;
      lost_nxt   = 1'b0;
      dir_nxt    = last_dir;
      search_nxt = search_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lost       <= 1'b0;
      last_dir   <= DIR_RIGHT;
      search_cnt <= '0;
      pwm_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      lost       <= lost_nxt;
      last_dir   <= dir_nxt;
      search_cnt <= search_nxt;
      pwm_cnt    <= pwm_cnt + 1'b1;
    end
  end

  // Output stage: wheel levels registered from the current counter and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      motorLeft  <= 1'b0;
      motorRight <= 1'b0;
    end else begin
      motorLeft  <= !stop && pwm_on(pwm_cnt, duty_left);
      motorRight <= !stop && pwm_on(pwm_cnt, duty_right);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer: a table of held-input phases with
// expected state/lost and wheel-high counts, then a reset-mid-SEARCH sequence.
module tb_line_follow_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       sensorLeft;
  logic       sensorRight;
  logic [3:0] duty_fast;
  logic [3:0] duty_slow;
  logic       motorLeft;
  logic       motorRight;
  logic [1:0] state_o;
  logic       lost;

  int n_cmp = 0;
  int n_bad = 0;

  line_follow_sequencer #(.DEB_CYCLES(4), .SEARCH_TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .sensorLeft  (sensorLeft),
    .sensorRight (sensorRight),
    .duty_fast   (duty_fast),
    .duty_slow   (duty_slow),
    .motorLeft   (motorLeft),
    .motorRight  (motorRight),
    .state_o     (state_o),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       sl;
    logic       sr;
    int         cyc;
    logic [1:0] st;
    logic       lost;
    logic       chkm;
    int         ml;
    int         mr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a_start, input logic a_stop, input logic a_sl,
                     input logic a_sr, input int a_cyc, input logic [1:0] a_st,
                     input logic a_lost, input logic a_chkm, input int a_ml,
                     input int a_mr);
    vec_t v;
    v.start = a_start; v.stop = a_stop; v.sl = a_sl; v.sr = a_sr;
    v.cyc = a_cyc; v.st = a_st; v.lost = a_lost; v.chkm = a_chkm;
    v.ml = a_ml; v.mr = a_mr;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ml;
    int mr;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    sensorLeft = 1'b1; sensorRight = 1'b1;
    duty_fast = 4'd8; duty_slow = 4'd3;
    step();
    step();
    check("reset state", 32'(state_o), 32'd0);
    check("reset lost", 32'(lost), 32'd0);
    check("reset motors", 32'({motorLeft, motorRight}), 32'd0);
    reset = 1'b0;

    //  start stop sl sr cyc  st lost chkm ml mr
    add(1, 0, 1, 1,  1, 1, 0, 0, 0, 0);  // IDLE -> RUN one cycle after start
    add(0, 0, 1, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 16, 1, 0, 1, 8, 8);  // both fast, 8/16
    add(0, 0, 0, 1,  3, 1, 0, 0, 0, 0);  // 3-cycle glitch: ignored
    add(0, 0, 1, 1, 16, 1, 0, 1, 8, 8);
    add(0, 0, 0, 1,  4, 1, 0, 0, 0, 0);  // filtered left drops on 4th cycle
    add(0, 0, 0, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 16, 1, 0, 1, 3, 8);  // left slow, last_dir LEFT
    add(0, 0, 0, 0,  4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 2, 0, 0, 0, 0);  // SEARCH entry
    add(0, 0, 0, 0,  9, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1,  3, 2, 0, 0, 0, 0);  // right sensor back at SEARCH cycle 10
    add(0, 0, 0, 1,  1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0, 0, 0);  // recovered
    add(0, 0, 0, 1, 16, 1, 0, 1, 3, 8);
    add(0, 0, 0, 0,  4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 2, 0, 0, 0, 0);  // SEARCH entry
    add(0, 0, 0, 0, 16, 2, 0, 1, 0, 8);  // spin left: right fast, left off
    add(0, 0, 0, 0, 47, 2, 0, 0, 0, 0);  // 63 cycles after entry: still SEARCH
    add(0, 0, 0, 0,  1, 3, 1, 0, 0, 0);  // 64th cycle: HALT, lost
    add(0, 0, 0, 0, 16, 3, 1, 1, 0, 0);
    add(1, 0, 0, 0,  1, 1, 0, 0, 0, 0);  // start from HALT clears lost
    add(0, 0, 0, 0,  1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 63, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 3, 1, 0, 0, 0);
    add(1, 1, 0, 0,  1, 0, 0, 0, 0, 0);  // start+stop in HALT -> IDLE
    add(0, 0, 0, 0, 16, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1,  4, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1,  4, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1,  1, 0, 0, 0, 0, 0);  // stop from RUN
    add(0, 0, 1, 1, 16, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0,  4, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 16, 1, 0, 1, 8, 3);  // right slow, last_dir RIGHT
    add(0, 0, 0, 0,  4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 2, 0, 0, 0, 0);  // SEARCH entry
    add(0, 0, 0, 0, 16, 2, 0, 1, 8, 0);  // spin right: left fast, right off
    add(0, 0, 0, 0, 43, 2, 0, 0, 0, 0);
    add(0, 0, 1, 0,  4, 2, 0, 0, 0, 0);  // filtered left rises at cycle 63
    add(0, 0, 1, 0,  1, 1, 0, 0, 0, 0);  // recovery beats timeout

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      sensorLeft = tbl[i].sl; sensorRight = tbl[i].sr;
      ml = 0; mr = 0;
      for (int k = 0; k < tbl[i].cyc; k++) begin
        step();
        ml += int'(motorLeft);
        mr += int'(motorRight);
      end
      check($sformatf("row%0d state", i), 32'(state_o), 32'(tbl[i].st));
      check($sformatf("row%0d lost", i), 32'(lost), 32'(tbl[i].lost));
      if (tbl[i].chkm) begin
        check($sformatf("row%0d left highs", i), 32'(ml), 32'(tbl[i].ml));
        check($sformatf("row%0d right highs", i), 32'(mr), 32'(tbl[i].mr));
      end
    end

    // Reset pulsed mid-SEARCH.
    start = 1'b0; stop = 1'b0; sensorLeft = 1'b0; sensorRight = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("pre-reset search", 32'(state_o), 32'd2);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1; start = 1'b1;
    step();
    check("mid-search reset state", 32'(state_o), 32'd0);
    check("mid-search reset motors", 32'({motorLeft, motorRight}), 32'd0);
    check("mid-search reset lost", 32'(lost), 32'd0);
    // Filters must come back as 1 and the PWM counter as 0.
    reset = 1'b0; sensorLeft = 1'b1; sensorRight = 1'b1;
    step();
    check("post-reset run", 32'(state_o), 32'd1);
    check("post-reset first motors", 32'({motorLeft, motorRight}), 32'd0);
    for (int k = 2; k <= 17; k++) begin
      logic want;
      step();
      want = (((k - 1) % 16) < 8);
      check($sformatf("post-reset state c%0d", k), 32'(state_o), 32'd1);
      check($sformatf("post-reset pwm L c%0d", k), 32'(motorLeft), 32'(want));
      check($sformatf("post-reset pwm R c%0d", k), 32'(motorRight), 32'(want));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
